// File: rtl/dac_spi_tx_if.sv
// Sample handshake between an upstream sample source (e.g. a DDS generator) and dac_spi_tx.
// Transfer happens on sample_valid && sample_ready at the rising clock edge.
interface dac_spi_tx_if #(
    parameter int DAC_N = 10
);
    logic [DAC_N-1:0] sample;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises one DAC sample per handshake into a 16-bit SPI mode-0 frame for an MCP49x1-style
// DAC, then strobes LDAC. Every output comes straight from a flop.
module dac_spi_tx #(
    parameter int         DAC_N   = 10,
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CFG     = 4'b0111
) (
    input  logic        clk,
    input  logic        rst,
    dac_spi_tx_if.slave s_if,
    output logic        busy,
    output logic        frame_done,
    output logic        dac_cs_n,
    output logic        dac_sck,
    output logic        dac_sdi,
    output logic        dac_ldac_n
);

    localparam int              HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0] HC_PRE  = HC_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        LATCH
    } state_t;

    state_t          state_reg;
    logic [HC_W-1:0] hc_reg;
    logic [3:0]      bit_cnt_reg;
    logic [15:0]     shreg_reg;
    logic            cs_n_reg;
    logic            sck_reg;
    logic            ldac_n_reg;
    logic            ready_reg;
    logic            busy_reg;
    logic            frame_done_reg;

    logic [11:0]     sample_aligned;
    logic [15:0]     frame;
    logic            hc_last;

    // Left-align the sample into the 12-bit data field, zero-padding the LSBs.
    genvar gi;
    for (gi = 0; gi < 12; gi++) begin : g_align
        if (gi >= 12 - DAC_N) begin : g_data
            assign sample_aligned[gi] = s_if.sample[gi - (12 - DAC_N)];
        end else begin : g_pad
            assign sample_aligned[gi] = 1'b0;
        end
    end

    assign frame   = {CFG, sample_aligned};
    assign hc_last = (hc_reg == HC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            hc_reg         <= '0;
            bit_cnt_reg    <= '0;
            shreg_reg      <= '0;
            cs_n_reg       <= 1'b1;
            sck_reg        <= 1'b0;
            ldac_n_reg     <= 1'b1;
            ready_reg      <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s_if.sample_valid) begin
                        state_reg <= SETUP;
                        hc_reg    <= '0;
                        shreg_reg <= frame;
                        cs_n_reg  <= 1'b0;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (hc_last) begin
                        state_reg   <= SHIFT;
                        hc_reg      <= '0;
                        sck_reg     <= 1'b1;
                        bit_cnt_reg <= '0;
                    end else begin
                        hc_reg <= hc_reg + 1'b1;
                    end
                end
                SHIFT: begin
                    if (hc_last) begin
                        hc_reg <= '0;
                        if (sck_reg) begin
                            sck_reg <= 1'b0;
                            // The last bit stays on sdi through HOLD; no shift after it.
                            if (bit_cnt_reg == 4'd15) begin
                                state_reg <= HOLD;
                            end else begin
                                shreg_reg   <= {shreg_reg[14:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end else begin
                            sck_reg <= 1'b1;
                        end
                    end else begin
                        hc_reg <= hc_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (hc_last) begin
                        state_reg      <= LATCH;
                        hc_reg         <= '0;
                        cs_n_reg       <= 1'b1;
                        shreg_reg      <= '0;
                        ldac_n_reg     <= 1'b0;
                        frame_done_reg <= (CLK_DIV == 1);
                    end else begin
                        hc_reg <= hc_reg + 1'b1;
                    end
                end
                LATCH: begin
                    if (hc_last) begin
                        state_reg  <= IDLE;
                        hc_reg     <= '0;
                        ldac_n_reg <= 1'b1;
                        ready_reg  <= 1'b1;
                        busy_reg   <= 1'b0;
                    end else begin
                        hc_reg         <= hc_reg + 1'b1;
                        frame_done_reg <= (hc_reg == HC_PRE);
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    hc_reg     <= '0;
                    cs_n_reg   <= 1'b1;
                    sck_reg    <= 1'b0;
                    shreg_reg  <= '0;
                    ldac_n_reg <= 1'b1;
                    ready_reg  <= 1'b1;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.sample_ready = ready_reg;
    assign busy              = busy_reg;
    assign frame_done        = frame_done_reg;
    assign dac_cs_n          = cs_n_reg;
    assign dac_sck           = sck_reg;
    assign dac_sdi           = shreg_reg[15];
    assign dac_ldac_n        = ldac_n_reg;

endmodule
